// File: rtl/victim_writeback_buffer.sv
// Writeback buffer for dirty victim-cache evictions: a small FIFO drained to memory
// with BUS_STORE commands, plus combinational forwarding of queued lines to MSHR lookups.
module victim_writeback_buffer #(
  parameter int XLEN            = 32,
  parameter int CACHE_LINE_BITS = 5,
  parameter int WB_DEPTH        = 4,
  parameter int N_LOOKUP        = 4,
  localparam int TW             = XLEN - CACHE_LINE_BITS - 3,
  localparam int PTR_W          = $clog2(WB_DEPTH),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [1:0]                           ev_valid,
  input  logic [1:0]                           ev_dirty,
  input  logic [1:0][TW-1:0]                   ev_tag,
  input  logic [1:0][CACHE_LINE_BITS-1:0]      ev_line_idx,
  input  logic [1:0][63:0]                     ev_data,
  output logic                                 wb_stall,
  output logic                                 overflow_err,
  output logic                                 mem_req,
  input  logic                                 mem_grant,
  output logic [1:0]                           proc2mem_command,
  output logic [XLEN-1:0]                      proc2mem_addr,
  output logic [63:0]                          proc2mem_data,
  input  logic [3:0]                           mem2proc_response,
  input  logic [N_LOOKUP-1:0]                  lookup_valid,
  input  logic [N_LOOKUP-1:0][XLEN-1:0]        lookup_addr,
  output logic [N_LOOKUP-1:0]                  hit_valid,
  output logic [N_LOOKUP-1:0][63:0]            hit_data,
  input  logic                                 flush_req,
  output logic                                 flush_done,
  output logic                                 dbg_state,
  output logic [CNT_W-1:0]                     dbg_count
);

  // Handshake: a store completes only in a cycle where mem_req, mem_grant and a
  // nonzero mem2proc_response coincide; otherwise the head entry is re-offered.

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d;
  logic                                overflow_q, overflow_d;
  logic [WB_DEPTH-1:0][XLEN-4:0]       line_q, line_d;
  logic [WB_DEPTH-1:0][63:0]           data_q, data_d;

  logic                                pop, want0, want1, acc0, acc1;
  logic [CNT_W-1:0]                    live, free;
  logic [PTR_W-1:0]                    wr1_ptr;

  always_comb begin
    pop        = (state_q == S_REQ) && mem_grant && (mem2proc_response != 4'd0);
    want0      = ev_valid[0] && ev_dirty[0];
    want1      = ev_valid[1] && ev_dirty[1];
    live       = count_q - CNT_W'(pop);
    free       = CNT_W'(WB_DEPTH) - live;
    // Row 0 is older, so it claims the last free slot before row 1 does.
    acc0       = want0 && (free != '0);
    acc1       = want1 && (free > CNT_W'(acc0));
    wr1_ptr    = tail_q + PTR_W'(acc0);
    line_d     = line_q;
    data_d     = data_q;
    if (acc0) begin
      line_d[tail_q] = {ev_tag[0], ev_line_idx[0]};
      data_d[tail_q] = ev_data[0];
    end
    if (acc1) begin
      line_d[wr1_ptr] = {ev_tag[1], ev_line_idx[1]};
      data_d[wr1_ptr] = ev_data[1];
    end
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
    count_d    = live + CNT_W'(acc0) + CNT_W'(acc1);
    overflow_d = overflow_q || (want0 && !acc0) || (want1 && !acc1);
    state_d    = (count_d != '0) ? S_REQ : S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
      line_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      line_q     <= line_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    mem_req          = (state_q == S_REQ);
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if ((state_q == S_REQ) && mem_grant) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = {line_q[head_q], 3'b000};
      proc2mem_data    = data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest copy.
  always_comb begin
    hit_valid = '0;
    hit_data  = '0;
    for (int p = 0; p < N_LOOKUP; p++) begin
      for (int k = 0; k < WB_DEPTH; k++) begin
        if (lookup_valid[p] && (CNT_W'(k) < count_q) &&
            (line_q[head_q + PTR_W'(k)] == lookup_addr[p][XLEN-1:3])) begin
          hit_valid[p] = 1'b1;
          hit_data[p]  = data_q[head_q + PTR_W'(k)];
        end
      end
    end
  end

  logic unused_lookup_low;
  assign unused_lookup_low = ^{lookup_addr[0][2:0], lookup_addr[N_LOOKUP-1][2:0]};

  assign wb_stall     = count_q >= CNT_W'(WB_DEPTH - 1);
  assign overflow_err = overflow_q;
  assign flush_done   = flush_req && (count_q == '0) && (state_q == S_IDLE);
  assign dbg_state    = state_q;
  assign dbg_count    = count_q;

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed bench for victim_writeback_buffer: enqueue, drain, retry, overflow,
// forwarding and flush/reset behaviour against hand-computed expectations.
module tb_victim_writeback_buffer;

  localparam int XLEN = 32;
  localparam int CLB  = 5;
  localparam int TW   = XLEN - CLB - 3;
  localparam int NL   = 4;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [1:0]               ev_valid, ev_dirty;
  logic [1:0][TW-1:0]       ev_tag;
  logic [1:0][CLB-1:0]      ev_line_idx;
  logic [1:0][63:0]         ev_data;
  logic                     wb_stall, overflow_err, mem_req, mem_grant;
  logic [1:0]               proc2mem_command;
  logic [XLEN-1:0]          proc2mem_addr;
  logic [63:0]              proc2mem_data;
  logic [3:0]               mem2proc_response;
  logic [NL-1:0]            lookup_valid;
  logic [NL-1:0][XLEN-1:0]  lookup_addr;
  logic [NL-1:0]            hit_valid;
  logic [NL-1:0][63:0]      hit_data;
  logic                     flush_req, flush_done, dbg_state;
  logic [2:0]               dbg_count;

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  victim_writeback_buffer dut (
    .clock(clock), .reset(reset),
    .ev_valid(ev_valid), .ev_dirty(ev_dirty), .ev_tag(ev_tag),
    .ev_line_idx(ev_line_idx), .ev_data(ev_data),
    .wb_stall(wb_stall), .overflow_err(overflow_err),
    .mem_req(mem_req), .mem_grant(mem_grant),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .hit_valid(hit_valid), .hit_data(hit_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mk_addr(input logic [TW-1:0] tag, input logic [CLB-1:0] idx);
    return {tag, idx, 3'b000};
  endfunction

  task automatic set_ev(input logic [1:0] v, input logic [1:0] d,
                        input logic [TW-1:0] t0, input logic [CLB-1:0] i0, input logic [63:0] d0,
                        input logic [TW-1:0] t1, input logic [CLB-1:0] i1, input logic [63:0] d1);
    ev_valid = v;  ev_dirty = d;
    ev_tag[0] = t0; ev_line_idx[0] = i0; ev_data[0] = d0;
    ev_tag[1] = t1; ev_line_idx[1] = i1; ev_data[1] = d1;
  endtask

  task automatic clear_ev();
    ev_valid = 2'b00;
    ev_dirty = 2'b00;
  endtask

  initial begin
    ev_valid = '0; ev_dirty = '0; ev_tag = '0; ev_line_idx = '0; ev_data = '0;
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    lookup_valid = '0; lookup_addr = '0; flush_req = 1'b0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_cmd", proc2mem_command, 0);
    check_eq("rst_stall", wb_stall, 0);
    check_eq("rst_overflow", overflow_err, 0);
    check_eq("rst_count", dbg_count, 0);
    @(negedge clock);
    reset = 1'b0;

    // Only the dirty row of a valid pair is queued; store offered next cycle
    set_ev(2'b11, 2'b01, 24'h10, 5'd1, 64'hA0A0_0000_0000_0001, 24'h55, 5'd2, 64'hDEAD);
    #1 check_eq("t1_pre_req", mem_req, 0);
    @(negedge clock);
    clear_ev();
    #1;
    check_eq("t1_count", dbg_count, 1);
    check_eq("t1_req", mem_req, 1);
    check_eq("t1_cmd_nogrant", proc2mem_command, 0);
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    #1;
    check_eq("t1_cmd", proc2mem_command, 2);
    check_eq("t1_addr", proc2mem_addr, mk_addr(24'h10, 5'd1));
    check_eq("t1_data", proc2mem_data, 64'hA0A0_0000_0000_0001);
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    #1;
    check_eq("t1_count_after", dbg_count, 0);
    check_eq("t1_req_after", mem_req, 0);

    // Two dirty rows drained back-to-back, row 0 first
    set_ev(2'b11, 2'b11, 24'h20, 5'd3, 64'hB0, 24'h21, 5'd4, 64'hC0);
    exp_q.push_back(mk_addr(24'h20, 5'd3));
    exp_q.push_back(mk_addr(24'h21, 5'd4));
    @(negedge clock);
    clear_ev();
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    #1;
    check_eq("t2_count", dbg_count, 2);
    check_eq("t2_addr0", proc2mem_addr, exp_q.pop_front());
    check_eq("t2_data0", proc2mem_data, 64'hB0);
    @(negedge clock);
    #1;
    check_eq("t2_addr1", proc2mem_addr, exp_q.pop_front());
    check_eq("t2_data1", proc2mem_data, 64'hC0);
    check_eq("t2_count1", dbg_count, 1);
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    #1 check_eq("t2_empty", dbg_count, 0);

    // Rejected responses keep the head; one pop when finally accepted
    set_ev(2'b01, 2'b01, 24'h30, 5'd5, 64'hD0, 24'h0, 5'd0, 64'h0);
    @(negedge clock);
    clear_ev();
    mem_grant = 1'b1; mem2proc_response = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t3_retry_addr", proc2mem_addr, mk_addr(24'h30, 5'd5));
      check_eq("t3_retry_data", proc2mem_data, 64'hD0);
      check_eq("t3_retry_count", dbg_count, 1);
      @(negedge clock);
    end
    mem2proc_response = 4'd2;
    #1 check_eq("t3_accept_addr", proc2mem_addr, mk_addr(24'h30, 5'd5));
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    #1 check_eq("t3_count_after", dbg_count, 0);

    // Fill to capacity, stall threshold, overflow on fifth row
    set_ev(2'b11, 2'b11, 24'h40, 5'd0, 64'hE0, 24'h41, 5'd1, 64'hE1);
    @(negedge clock);
    set_ev(2'b01, 2'b01, 24'h42, 5'd2, 64'hE2, 24'h0, 5'd0, 64'h0);
    #1;
    check_eq("t4_count2", dbg_count, 2);
    check_eq("t4_stall2", wb_stall, 0);
    @(negedge clock);
    set_ev(2'b01, 2'b01, 24'h43, 5'd3, 64'hE3, 24'h0, 5'd0, 64'h0);
    #1;
    check_eq("t4_count3", dbg_count, 3);
    check_eq("t4_stall3", wb_stall, 1);
    @(negedge clock);
    set_ev(2'b01, 2'b01, 24'h44, 5'd4, 64'hE4, 24'h0, 5'd0, 64'h0);
    #1;
    check_eq("t4_count4", dbg_count, 4);
    check_eq("t4_overflow_pre", overflow_err, 0);
    @(negedge clock);
    clear_ev();
    #1;
    check_eq("t4_count_full", dbg_count, 4);
    check_eq("t4_overflow", overflow_err, 1);
    // Full FIFO accepts a row when the head pops in the same cycle
    set_ev(2'b01, 2'b01, 24'h45, 5'd5, 64'hE5, 24'h0, 5'd0, 64'h0);
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    #1 check_eq("t4_pop_addr", proc2mem_addr, mk_addr(24'h40, 5'd0));
    @(negedge clock);
    clear_ev();
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    lookup_valid = 4'b0011;
    lookup_addr[0] = mk_addr(24'h40, 5'd0);
    lookup_addr[1] = mk_addr(24'h45, 5'd5);
    #1;
    check_eq("t4_count_swap", dbg_count, 4);
    check_eq("t4_overflow_sticky", overflow_err, 1);
    check_eq("t4_popped_miss", hit_valid[0], 0);
    check_eq("t4_new_hit", hit_valid[1], 1);
    check_eq("t4_new_data", hit_data[1], 64'hE5);
    lookup_valid = '0;
    reset = 1'b1;
    #1;
    check_eq("t4_rst_overflow", overflow_err, 0);
    check_eq("t4_rst_count", dbg_count, 0);
    @(negedge clock);
    reset = 1'b0;

    // Forwarding: youngest duplicate wins, incoming rows invisible until next cycle
    set_ev(2'b01, 2'b01, 24'h1, 5'd0, 64'hAAAA, 24'h0, 5'd0, 64'h0);
    @(negedge clock);
    set_ev(2'b11, 2'b11, 24'h1, 5'd0, 64'hBBBB, 24'h77, 5'd3, 64'hFFFF);
    lookup_valid = 4'b0101;
    lookup_addr[0] = 32'h0000_0200;
    lookup_addr[2] = 32'h0000_0104;
    lookup_addr[3] = 32'h0000_0100;
    #1;
    check_eq("t5_hit_old", hit_valid[2], 1);
    check_eq("t5_data_old", hit_data[2], 64'hAAAA);
    @(negedge clock);
    clear_ev();
    #1;
    check_eq("t5_hit", hit_valid[2], 1);
    check_eq("t5_data_young", hit_data[2], 64'hBBBB);
    check_eq("t5_miss", hit_valid[0], 0);
    check_eq("t5_miss_data", hit_data[0], 0);
    check_eq("t5_invalid_port", hit_valid[3], 0);
    lookup_valid = '0;

    // Flush completion after draining the three queued entries
    flush_req = 1'b1;
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    #1 check_eq("t6_flush_busy", flush_done, 0);
    @(negedge clock);
    @(negedge clock);
    #1 check_eq("t6_flush_last", flush_done, 0);
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    #1;
    check_eq("t6_flush_done", flush_done, 1);
    check_eq("t6_count", dbg_count, 0);
    flush_req = 1'b0;
    #1 check_eq("t6_flush_drop", flush_done, 0);

    // Asynchronous reset while a store is being offered
    set_ev(2'b01, 2'b01, 24'h88, 5'd7, 64'h1234, 24'h0, 5'd0, 64'h0);
    @(negedge clock);
    clear_ev();
    mem_grant = 1'b1; mem2proc_response = 4'd0;
    #1 check_eq("t7_cmd_before", proc2mem_command, 2);
    #2 reset = 1'b1;
    #1;
    check_eq("t7_req", mem_req, 0);
    check_eq("t7_cmd", proc2mem_command, 0);
    check_eq("t7_addr", proc2mem_addr, 0);
    check_eq("t7_count", dbg_count, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_grant = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
